divider_n: RTL and testbench

DIVIDER_N -- requirements
Module: divider_n

---
 rtl/divider_n.sv | 123 ++++++++++++
 tb/tb_divider_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/divider_n.sv
// Iterative shift-subtract divider, one quotient bit per cycle, signed or unsigned.
// Optional macro DIVIDER_N_DIV0_FAST_EN: early divide-by-zero exit with div0 flag.
module divider_n #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic             signed_in,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             valid_out,
   output logic             div0
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] a;       // dividend magnitude, shifted into quotient bits
   logic [WIDTH-1:0] b;       // divisor magnitude
   logic [WIDTH:0]   r;       // partial remainder
   logic [CW-1:0]    cnt;
   logic             sm, qs, rs;
   logic             accept, zero_det;
   logic [WIDTH+1:0] shifted, diff;

   assign accept  = valid_in & ready_out;
   assign shifted = {r, a[WIDTH-1]};
   assign diff    = shifted - {2'b00, b};

`ifdef DIVIDER_N_DIV0_FAST_EN
   logic zf, div0_r;
   assign zero_det = (divisor == '0);
   assign div0     = div0_r;
`else
   assign zero_det = 1'b0;
   assign div0     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = zero_det ? FIX : PREP;
         PREP: state_nx = CALC;
         CALC: if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready_out = (state == IDLE);
      valid_out = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIVIDER_N_DIV0_FAST_EN
         div0_r    <= 1'b0;
         zf        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               a   <= dividend;
               b   <= divisor;
               sm  <= signed_in;
               cnt <= '0;
`ifdef DIVIDER_N_DIV0_FAST_EN
               zf  <= zero_det;
`endif
            end
            PREP: begin
               qs <= sm & (a[WIDTH-1] ^ b[WIDTH-1]);
               rs <= sm & a[WIDTH-1];
               if (sm & a[WIDTH-1]) a <= -a;
               if (sm & b[WIDTH-1]) b <= -b;
               r  <= '0;
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               // restoring step: keep the difference only when it did not go negative
               if (!diff[WIDTH+1]) begin
                  r <= diff[WIDTH:0];
                  a <= {a[WIDTH-2:0], 1'b1};
               end else begin
                  r <= shifted[WIDTH:0];
                  a <= {a[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
`ifdef DIVIDER_N_DIV0_FAST_EN
               div0_r <= zf;
               if (zf) begin
                  quotient  <= '1;
                  remainder <= a;
               end else begin
                  quotient  <= qs ? -a : a;
                  remainder <= rs ? -r[WIDTH-1:0] : r[WIDTH-1:0];
               end
`else
               quotient  <= qs ? -a : a;
               remainder <= rs ? -r[WIDTH-1:0] : r[WIDTH-1:0];
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_n.sv
// Scoreboard bench for divider_n: driver queues expected results, monitor checks on valid_out.
module tb_divider_n;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid_in = 1'b0;
   logic         signed_in = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         ready_out, valid_out, div0;
   logic [W-1:0] quotient, remainder;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         d0;
      int           acc;
      int           lat;
      string        name;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   divider_n #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
      .signed_in(signed_in), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .valid_out(valid_out), .div0(div0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic int lat_of(input logic [W-1:0] dv);
`ifdef DIVIDER_N_DIV0_FAST_EN
      if (dv == '0) return 2;
`endif
      return W + 2;
   endfunction

   // monitor: every valid_out pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_q"}, quotient, e.q);
            chk({e.name, "_r"}, remainder, e.r);
            chk({e.name, "_div0"}, W'(div0), W'(e.d0));
            chk_int({e.name, "_lat"}, cyc - e.acc, e.lat);
         end
      end
   end

   task automatic issue(input string nm, input logic sg, input logic [W-1:0] dd,
                        input logic [W-1:0] dv, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic d0, input bit push);
      int budget;
      exp_t e;
      budget = 0;
      @(negedge clk);
      while (ready_out !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (ready_out !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_ready_timeout: got ready_out=%b expected 1", nm, ready_out);
         return;
      end
      valid_in  = 1'b1;
      signed_in = sg;
      dividend  = dd;
      divisor   = dv;
      if (push) begin
         e.q = q; e.r = r; e.d0 = d0; e.acc = cyc + 1; e.lat = lat_of(dv); e.name = nm;
         sbq.push_back(e);
      end
      @(negedge clk);
      valid_in = 1'b0;
      chk({nm, "_busy"}, W'(ready_out), W'(0));
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sbq.size() != 0 && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      if (sbq.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_q"}, quotient, '0);
      chk({nm, "_r"}, remainder, '0);
      chk({nm, "_div0"}, W'(div0), W'(0));
      chk({nm, "_vout"}, W'(valid_out), W'(0));
      chk({nm, "_ready"}, W'(ready_out), W'(1));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_reset_state("reset");

      issue("neg_neg",  1'b1, 16'hB848, 16'hFDE4, 16'h0022, 16'h0000, 1'b0, 1'b1); drain();
      issue("m7_div2_s", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1); drain();
      issue("m7_div2_u", 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 1'b1); drain();
      issue("min_m1",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1); drain();
      issue("p7_m2_s",  1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b1); drain();
      issue("max_u1",   1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1); drain();
      issue("small_big", 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 1'b1); drain();

      // abort a request mid-calculation; no result may appear
      issue("abort", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state("abort_reset");
      repeat (30) @(negedge clk);
      issue("after_abort", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1); drain();

      // valid_in held high: one accept per IDLE cycle
      begin
         int pushed, budget;
         exp_t e;
         pushed = 0;
         budget = 0;
         @(negedge clk);
         valid_in = 1'b1; signed_in = 1'b0; dividend = 16'd200; divisor = 16'd3;
         while (pushed < 3 && budget < 200) begin
            if (ready_out === 1'b1) begin
               e.q = 16'd66; e.r = 16'd2; e.d0 = 1'b0; e.acc = cyc + 1; e.lat = W + 2; e.name = "b2b";
               sbq.push_back(e);
               pushed++;
            end
            @(negedge clk);
            budget++;
            if (budget == 5) chk("b2b_busy", W'(ready_out), W'(0));
         end
         valid_in = 1'b0;
         chk_int("b2b_accepts", pushed, 3);
         drain();
      end

`ifdef DIVIDER_N_DIV0_FAST_EN
      issue("div0_u", 1'b0, 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b1); drain();
      issue("div0_s", 1'b1, 16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, 1'b1); drain();
      issue("after_div0", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1); drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
